// File: rtl/seq_window_monitor.sv
// Multi-channel synthesizable first_match(req ##[MIN_DLY:MAX_DLY] ack) checker
// with a same-cycle intersect pulse, sticky fail flag and saturating fail counter.

module seq_window_ch #(
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 8,
  parameter int CNT_W      = 8,
  parameter int EARLY_FAIL = 1,
  parameter int RETRIGGER  = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic req_i,
  input  logic ack_i,
  output logic busy_o,
  output logic pass_nx_o,
  output logic fail_nx_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_ok, ack_early, timeout;

  assign ack_ok    = ack_i && (cnt_q >= CNT_W'(MIN_DLY));
  assign ack_early = ack_i && !ack_ok && (EARLY_FAIL != 0);
  assign timeout   = (MAX_DLY != 0) && (cnt_q == CNT_W'(MAX_DLY)) && !ack_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_nx_o = 1'b0;
    fail_nx_o = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        // ack alongside req in IDLE is dropped: zero delay is never a match
        S_IDLE: begin
          if (req_i) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (ack_ok) begin
            pass_nx_o = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
          end else if (ack_early || timeout) begin
            fail_nx_o = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
          end else if (req_i && (RETRIGGER != 0)) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == S_WAIT);

endmodule

module seq_window_monitor #(
  parameter int                NUM_CH     = 4,
  parameter int                MIN_DLY    = 1,
  parameter int                MAX_DLY    = 8,
  parameter int                CNT_W      = 8,
  parameter int                EARLY_FAIL = 1,
  parameter int                RETRIGGER  = 0,
  parameter logic [NUM_CH-1:0] ISECT_MASK = {NUM_CH{1'b1}}
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] pass_o,
  output logic [NUM_CH-1:0] fail_o,
  output logic              isect_pass_o,
  output logic              fail_sticky_o,
  output logic [15:0]       fail_count_o
);

  localparam int PW = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] pass_nx, fail_nx;
  logic [NUM_CH-1:0] pass_q, fail_q;
  logic              isect_q, isect_d;
  logic              sticky_q, sticky_d;
  logic [15:0]       count_q, count_d;
  logic [PW-1:0]     pop;
  logic [16:0]       sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    seq_window_ch #(
      .MIN_DLY   (MIN_DLY),
      .MAX_DLY   (MAX_DLY),
      .CNT_W     (CNT_W),
      .EARLY_FAIL(EARLY_FAIL),
      .RETRIGGER (RETRIGGER)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .enable_i (enable_i),
      .req_i    (req_i[g]),
      .ack_i    (ack_i[g]),
      .busy_o   (busy_o[g]),
      .pass_nx_o(pass_nx[g]),
      .fail_nx_o(fail_nx[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + PW'(fail_nx[i]);
  end

  assign sum     = {1'b0, count_q} + 17'(pop);
  assign isect_d = (ISECT_MASK != '0) && ((pass_nx & ISECT_MASK) == ISECT_MASK);

  // clr wins over accumulation but still records fails from the same cycle
  always_comb begin
    count_d  = sum[16] ? 16'hFFFF : sum[15:0];
    sticky_d = sticky_q | (|fail_nx);
    if (clr_i) begin
      count_d  = 16'(pop);
      sticky_d = |fail_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pass_q   <= '0;
      fail_q   <= '0;
      isect_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      pass_q   <= pass_nx;
      fail_q   <= fail_nx;
      isect_q  <= isect_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign isect_pass_o  = isect_q;
  assign fail_sticky_o = sticky_q;
  assign fail_count_o  = count_q;

endmodule

// File: tb/tb_seq_window_monitor.sv
// Bench for seq_window_monitor: four configurations share one stimulus stream;
// directed table and sequences plus a timestamp-based reference model.

module tb_seq_window_monitor;

  logic       clk;
  logic       rst_n, enable, clr;
  logic [3:0] req, ack;

  logic [3:0]  d_busy [4];
  logic [3:0]  d_pass [4];
  logic [3:0]  d_fail [4];
  logic        d_isect [4];
  logic        d_sticky [4];
  logic [15:0] d_cnt [4];

  // u0: window 3..10, early fail, mask 0011
  // u1: as u0 with retrigger, full mask
  // u2: unbounded window, early acks ignored
  // u3: window 1..1, for fast timeouts
  localparam int P_MIN  [4] = '{3, 3, 3, 1};
  localparam int P_MAX  [4] = '{10, 10, 0, 1};
  localparam int P_EF   [4] = '{1, 1, 0, 1};
  localparam int P_RT   [4] = '{0, 1, 0, 0};
  localparam int P_MASK [4] = '{3, 15, 15, 15};

  seq_window_monitor #(.NUM_CH(4), .MIN_DLY(3), .MAX_DLY(10), .CNT_W(8), .EARLY_FAIL(1),
                       .RETRIGGER(0), .ISECT_MASK(4'b0011)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clr_i(clr), .req_i(req), .ack_i(ack),
    .busy_o(d_busy[0]), .pass_o(d_pass[0]), .fail_o(d_fail[0]), .isect_pass_o(d_isect[0]),
    .fail_sticky_o(d_sticky[0]), .fail_count_o(d_cnt[0]));

  seq_window_monitor #(.NUM_CH(4), .MIN_DLY(3), .MAX_DLY(10), .CNT_W(8), .EARLY_FAIL(1),
                       .RETRIGGER(1), .ISECT_MASK(4'b1111)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clr_i(clr), .req_i(req), .ack_i(ack),
    .busy_o(d_busy[1]), .pass_o(d_pass[1]), .fail_o(d_fail[1]), .isect_pass_o(d_isect[1]),
    .fail_sticky_o(d_sticky[1]), .fail_count_o(d_cnt[1]));

  seq_window_monitor #(.NUM_CH(4), .MIN_DLY(3), .MAX_DLY(0), .CNT_W(8), .EARLY_FAIL(0),
                       .RETRIGGER(0), .ISECT_MASK(4'b1111)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clr_i(clr), .req_i(req), .ack_i(ack),
    .busy_o(d_busy[2]), .pass_o(d_pass[2]), .fail_o(d_fail[2]), .isect_pass_o(d_isect[2]),
    .fail_sticky_o(d_sticky[2]), .fail_count_o(d_cnt[2]));

  seq_window_monitor #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(1), .CNT_W(8), .EARLY_FAIL(1),
                       .RETRIGGER(0), .ISECT_MASK(4'b1111)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clr_i(clr), .req_i(req), .ack_i(ack),
    .busy_o(d_busy[3]), .pass_o(d_pass[3]), .fail_o(d_fail[3]), .isect_pass_o(d_isect[3]),
    .fail_sticky_o(d_sticky[3]), .fail_count_o(d_cnt[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_model = 0;

  // Reference model: an attempt is "open since cycle start"; elapsed = now - start.
  bit         m_open  [4][4];
  int         m_start [4][4];
  logic [3:0] e_busy [4];
  logic [3:0] e_pass [4];
  logic [3:0] e_fail [4];
  logic       e_isect [4];
  logic       e_sticky [4];
  int         e_cnt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_eval();
    for (int d = 0; d < 4; d++) begin
      logic [3:0] pn, fn;
      int pc, k;
      pn = '0;
      fn = '0;
      if (!rst_n) begin
        for (int c = 0; c < 4; c++) m_open[d][c] = 0;
        e_busy[d] = '0; e_pass[d] = '0; e_fail[d] = '0;
        e_isect[d] = 0; e_sticky[d] = 0; e_cnt[d] = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (!enable) begin
            m_open[d][c] = 0;
          end else if (m_open[d][c]) begin
            k = cyc - m_start[d][c];
            if (k > 255) k = 255;
            if (ack[c] && k >= P_MIN[d]) begin
              pn[c] = 1'b1; m_open[d][c] = 0;
            end else if (ack[c] && P_EF[d] != 0) begin
              fn[c] = 1'b1; m_open[d][c] = 0;
            end else if (P_MAX[d] != 0 && k == P_MAX[d]) begin
              fn[c] = 1'b1; m_open[d][c] = 0;
            end else if (req[c] && P_RT[d] != 0) begin
              m_start[d][c] = cyc;
            end
          end else if (req[c]) begin
            m_open[d][c] = 1;
            m_start[d][c] = cyc;
          end
          e_busy[d][c] = m_open[d][c];
        end
        pc = $countones(fn);
        e_pass[d]  = pn;
        e_fail[d]  = fn;
        e_isect[d] = (P_MASK[d] != 0) && ((int'(pn) & P_MASK[d]) == P_MASK[d]);
        if (clr) begin
          e_cnt[d] = pc;
          e_sticky[d] = (pc != 0);
        end else begin
          e_cnt[d] = (e_cnt[d] + pc > 65535) ? 65535 : e_cnt[d] + pc;
          e_sticky[d] = e_sticky[d] | (pc != 0);
        end
      end
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    if (chk_model) begin
      for (int d = 0; d < 4; d++)
        check($sformatf("model_u%0d", d),
              {d_busy[d], d_pass[d], d_fail[d], d_isect[d], d_sticky[d], d_cnt[d]},
              {e_busy[d], e_pass[d], e_fail[d], e_isect[d], e_sticky[d], 16'(e_cnt[d])});
    end
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; ack = '0; clr = 0;
    step();
    rst_n = 1;
  endtask

  typedef struct {
    logic [3:0] req, ack, busy, pass, fail;
    logic       isect;
  } vec_t;

  vec_t tbl [26];
  int   seen;

  initial begin
    // u0 vectors: {req, ack} for one cycle, expected {busy, pass, fail, isect} next cycle
    tbl[0]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[9]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
    tbl[11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[13] = '{4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[14] = '{4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{4'h0, 4'h3, 4'h0, 4'h3, 4'h0, 1'b1};
    tbl[16] = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[18] = '{4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[19] = '{4'h0, 4'h1, 4'h2, 4'h1, 4'h0, 1'b0};
    tbl[20] = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 1'b0};
    tbl[21] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[22] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[23] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[24] = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[25] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    rst_n = 0; enable = 1; clr = 0; req = '0; ack = '0;
    step();
    step();
    for (int d = 0; d < 4; d++)
      check($sformatf("reset_u%0d", d),
            {d_busy[d], d_pass[d], d_fail[d], d_isect[d], d_sticky[d], d_cnt[d]}, 32'h0);
    rst_n = 1;

    // first_match, idle ack, early fail, intersect, back-to-back, complete-cycle req
    for (int i = 0; i < 26; i++) begin
      req = tbl[i].req;
      ack = tbl[i].ack;
      step();
      check($sformatf("tbl_row%0d", i), {d_busy[0], d_pass[0], d_fail[0], 3'b0, d_isect[0]},
            {tbl[i].busy, tbl[i].pass, tbl[i].fail, 3'b0, tbl[i].isect});
    end
    req = '0; ack = '0;
    check("tbl_count", {15'b0, d_sticky[0], d_cnt[0]}, {15'b0, 1'b1, 16'd1});

    // timeout at k == MAX_DLY; unbounded instance keeps waiting
    req = 4'h1; step(); req = '0;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 9) check("timeout_pre", {d_busy[0][0], d_fail[0][0]}, 2'b10);
    end
    check("timeout_fail", {d_busy[0][0], d_fail[0][0], d_sticky[0]}, 3'b011);
    check("timeout_count", d_cnt[0], 32'd2);
    check("unbounded_busy", d_busy[2][0], 1'b1);

    // reset while waiting discards the attempt silently
    req = 4'h1; step(); req = '0; step(); step();
    rst_n = 0; step();
    check("midwait_reset", {d_busy[0], d_pass[0], d_fail[0], d_isect[0], d_sticky[0], d_cnt[0]}, 32'h0);
    rst_n = 1;
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      seen += d_fail[0][0] | d_busy[0][0];
    end
    check("after_reset_quiet", seen, 0);

    // EARLY_FAIL=0: early ack ignored, later ack passes
    req = 4'h1; step(); req = '0; step();
    ack = 4'h1; step(); ack = '0;
    check("early_ignored", {d_busy[2][0], d_fail[2][0]}, 2'b10);
    check("early_fail_u0", d_fail[0][0], 1'b1);
    step();
    ack = 4'h1; step(); ack = '0;
    check("late_pass_u2", {d_busy[2][0], d_pass[2][0]}, 2'b01);

    // unbounded window: ack 300 cycles after req
    req = 4'h1; step(); req = '0;
    seen = 0;
    for (int j = 1; j < 300; j++) begin
      step();
      seen += d_fail[2][0];
    end
    check("unbounded_wait", {d_busy[2][0], 31'(seen)}, {1'b1, 31'd0});
    ack = 4'h1; step(); ack = '0;
    check("unbounded_pass", {d_pass[2][0], d_fail[2][0], d_cnt[2]}, {1'b1, 1'b0, 16'd0});

    // retrigger restarts the window; without it the same stream passes
    do_reset();
    req = 4'h1; step(); req = '0; step(); step(); step();
    req = 4'h1; step(); req = '0; step();
    ack = 4'h1; step(); ack = '0;
    check("retrig_fail_u1", {d_pass[1][0], d_fail[1][0]}, 2'b01);
    check("noretrig_pass_u0", {d_pass[0][0], d_fail[0][0]}, 2'b10);

    // enable low forces idle and suppresses pulses
    req = 4'h1; step(); req = '0; step();
    enable = 0; step();
    check("disable_idle", {d_busy[0], d_pass[0], d_fail[0]}, 12'h0);
    enable = 1; ack = 4'h1; step(); ack = '0;
    check("reenable_no_pass", {d_busy[0], d_pass[0], d_fail[0]}, 12'h0);

    // saturation on u3 (2-cycle timeouts on all channels)
    do_reset();
    for (int r = 0; r < 16383; r++) begin
      req = 4'hF; step(); req = '0; step();
    end
    req = 4'h3; step(); req = '0; step();
    check("count_fffe", d_cnt[3], 32'hFFFE);
    req = 4'hF; step(); req = '0; step();
    check("count_sat", {d_fail[3], d_cnt[3]}, {4'hF, 16'hFFFF});
    req = 4'h1; step(); req = '0;
    clr = 1; step(); clr = 0;
    check("clr_with_fail", {d_sticky[3], d_cnt[3]}, {1'b1, 16'd1});
    clr = 1; step(); clr = 0;
    check("clr_alone", {d_sticky[3], d_cnt[3]}, {1'b0, 16'd0});

    // random traffic against the reference model
    do_reset();
    chk_model = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 19) != 0);
      clr    = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < 4; c++) begin
        req[c] = ($urandom_range(0, 2) == 0);
        ack[c] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    chk_model = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
